// File: rtl/hazard_ctrl_pkg.sv
// ------------------------------------------------------------------
// hazard_ctrl_pkg: shared state encodings and widths for hazard_ctrl
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package hazard_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  // 2'd3 is unused; the sequencer treats it as RUN.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ------------------------------------------------------------------
// hazard_detect: combinational load-use comparator (shared with forwarding)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  output logic                  load_use
);

  logic rd_nonzero;
  logic hit_rs1;
  logic hit_rs2;

  // x0 is hard-wired to zero, so a load into it can never create a hazard.
  assign rd_nonzero = (idex_rd != '0);
  assign hit_rs1    = id_uses_rs1 & (idex_rd == id_rs1);
  assign hit_rs2    = id_uses_rs2 & (idex_rd == id_rs2);
  assign load_use   = idex_memread & rd_nonzero & (hit_rs1 | hit_rs2);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ------------------------------------------------------------------
// hazard_ctrl: load-use / branch-flush / memory-wait pipeline sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  exmem_memread,
  input  logic                  exmem_memwrite,
  input  logic                  dmem_ready,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  ctrl_clear,
  output logic                  pipe_freeze,
  output logic                  mem_err,
  output logic [15:0]           stall_cycles,
  output logic [1:0]            state_o
);

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [8:0] TIMEOUT_LIM  = 9'(MEM_TIMEOUT);

  state_t      state_q,      state_d;
  logic [3:0]  flush_cnt_q,  flush_cnt_d;
  logic [7:0]  wait_cnt_q,   wait_cnt_d;
  logic        mem_err_q,    mem_err_d;
  logic [15:0] stall_cnt_q,  stall_cnt_d;

  logic load_use;
  logic mem_busy;
  logic wait_last;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_detect (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .load_use     (load_use)
  );

  assign mem_busy  = (exmem_memread | exmem_memwrite) & ~dmem_ready & ~mem_err_q;
  // wait_cnt_q is zero in RUN, so +1 is the number of frozen cycles including this one.
  assign wait_last = (({1'b0, wait_cnt_q} + 9'd1) >= TIMEOUT_LIM);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    ctrl_clear  = 1'b0;
    pipe_freeze = 1'b0;

    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_busy) begin
          pipe_freeze = 1'b1;
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          if (wait_last) begin
            mem_err_d  = 1'b1;
            wait_cnt_d = '0;
            state_d    = ST_RUN;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            state_d    = ST_MEM_WAIT;
          end
        end else begin
          wait_cnt_d = '0;
          state_d    = ST_RUN;
          if (branch_taken) begin
            ifid_flush = 1'b1;
            ctrl_clear = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d     = ST_FLUSH;
              flush_cnt_d = FLUSH_RELOAD;
            end
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctrl_clear = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        // EX holds a bubble here, so branch_taken is deliberately ignored.
        if (mem_busy) begin
          pipe_freeze = 1'b1;
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
        end else begin
          ifid_flush = 1'b1;
          ctrl_clear = 1'b1;
          if (flush_cnt_q <= 4'd1) begin
            flush_cnt_d = '0;
            state_d     = ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
        wait_cnt_d  = '0;
      end
    endcase

    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      ctrl_clear  = 1'b1;
      pipe_freeze = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cnt_q;
  assign state_o      = state_q;

endmodule

`default_nettype wire
